// File: rtl/input_debounce.sv
// Per-channel input debouncer: 2-flop synchronizer followed by a stability counter.
// Optional rise/fall pulse outputs are enabled by defining DEBOUNCE_EDGE_EN.
module input_debounce #(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = 1000,
  parameter bit RESET_VAL     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] settling
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  localparam int            CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  // No handshake: sw_out/settling are plain levels, valid every cycle once rst is low.
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] out_nxt;
  logic [WIDTH-1:0] set_nxt;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];

  // Any cycle where s2 agrees with sw_out restarts the count from zero.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      out_nxt[i] = sw_out[i];
      cnt_nxt[i] = '0;
      if (s2[i] != sw_out[i]) begin
        if (cnt[i] == LAST) begin
          out_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
      set_nxt[i] = (cnt_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= {WIDTH{RESET_VAL}};
      s2       <= {WIDTH{RESET_VAL}};
      sw_out   <= {WIDTH{RESET_VAL}};
      settling <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1       <= sw_in;
      s2       <= s1;
      sw_out   <= out_nxt;
      settling <= set_nxt;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  // Pulses are derived from the counter decision, so a reset load never pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= out_nxt & ~sw_out;
      fall <= ~out_nxt & sw_out;
    end
  end
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce: directed test-plan sequences with literal
// expectations plus randomized stimulus against a history-window reference model.
module tb_input_debounce;
  localparam int W = 2;
  localparam int S = 4;
  localparam bit RV = 1'b0;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw_in;
  logic [W-1:0] sw_out;
  logic [W-1:0] settling;
`ifdef DEBOUNCE_EDGE_EN
  logic [W-1:0] rise;
  logic [W-1:0] fall;
`endif

  input_debounce #(.WIDTH(W), .STABLE_CYCLES(S), .RESET_VAL(RV)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_in    (sw_in),
    .sw_out   (sw_out),
    .settling (settling)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .rise     (rise),
    .fall     (fall)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  // Reference model: s2 history since last reset; a channel accepts a new level
  // once the last S synchronized samples all disagree with its current output.
  logic [W-1:0] m_s1, m_s2, m_out, m_set, m_rise, m_fall;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    logic [W-1:0] cur;
    bit all_diff;
    if (rst) begin
      m_s1 = {W{RV}}; m_s2 = {W{RV}}; m_out = {W{RV}};
      m_set = '0; m_rise = '0; m_fall = '0;
      exp_q.delete();
    end else begin
      cur  = m_s2;
      m_s2 = m_s1;
      m_s1 = sw_in;
      exp_q.push_back(cur);
      if (exp_q.size() > S) void'(exp_q.pop_front());
      m_rise = '0; m_fall = '0;
      for (int c = 0; c < W; c++) begin
        all_diff = (exp_q.size() == S);
        foreach (exp_q[k]) if (exp_q[k][c] == m_out[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_rise[c] = cur[c];
          m_fall[c] = ~cur[c];
          m_out[c]  = cur[c];
          m_set[c]  = 1'b0;
        end else begin
          m_set[c]  = (cur[c] != m_out[c]);
        end
      end
    end
  end

  // compare process: every cycle once reset has been applied
  always @(negedge clk) begin
    if (started) begin
      n_vec++;
      if (sw_out !== m_out) begin
        n_fail++;
        $display("FAIL sw_out t=%0t got=%b exp=%b", $time, sw_out, m_out);
      end
      n_vec++;
      if (settling !== m_set) begin
        n_fail++;
        $display("FAIL settling t=%0t got=%b exp=%b", $time, settling, m_set);
      end
`ifdef DEBOUNCE_EDGE_EN
      n_vec++;
      if (rise !== m_rise || fall !== m_fall) begin
        n_fail++;
        $display("FAIL edges t=%0t got rise=%b fall=%b exp rise=%b fall=%b",
                 $time, rise, fall, m_rise, m_fall);
      end
`endif
    end
  end

  // driver tasks
  task automatic step(input logic r, input logic [W-1:0] v);
    rst   = r;
    sw_in = v;
    @(posedge clk);
    #1;
    if (r) started = 1'b1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sw_in = '0;
    @(negedge clk);

    // reset release with inputs high
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b11);
      chk("rst_out", sw_out, 2'b00);
      chk("rst_set", settling, 2'b00);
    end
    step(1'b0, 2'b11);
    chk("rel_out", sw_out, 2'b00);
    chk("rel_set", settling, 2'b00);
    for (int i = 0; i < 10; i++) step(1'b0, 2'b00);

    // clean edge latency on channel 0
    for (int e = 1; e <= 6; e++) begin
      step(1'b0, 2'b01);
      chk1("clean_out0", sw_out[0], (e >= 6));
      chk1("clean_set0", settling[0], (e >= 3 && e <= 5));
      chk1("clean_out1", sw_out[1], 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 2'b01);

    // glitch on channel 1 shorter than S
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b11);
      chk1("glitch_out1", sw_out[1], 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'b01);
      chk1("glitch_out1", sw_out[1], 1'b0);
    end
    chk1("glitch_set1_clear", settling[1], 1'b0);

    // bounce then settle on channel 0
    for (int i = 0; i < 10; i++) step(1'b0, 2'b00);
    chk("bounce_pre", sw_out, 2'b00);
    step(1'b0, 2'b01); step(1'b0, 2'b00); step(1'b0, 2'b01); step(1'b0, 2'b00);
    step(1'b0, 2'b01);
    for (int e = 2; e <= 6; e++) begin
      step(1'b0, 2'b01);
      chk1("bounce_out0", sw_out[0], (e >= 6));
    end

    // reset in the middle of a pending count
    for (int i = 0; i < 10; i++) step(1'b0, 2'b00);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b01);
    chk1("mid_pending", settling[0], 1'b1);
    step(1'b1, 2'b01);
    chk("mid_rst_out", sw_out, 2'b00);
    chk("mid_rst_set", settling, 2'b00);
    for (int e = 1; e <= 6; e++) begin
      step(1'b0, 2'b01);
      chk1("mid_after_out0", sw_out[0], (e >= 6));
    end

    // randomized: slow-changing inputs with occasional bounce and rare reset
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] v;
      logic r;
      v = sw_in;
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 9) == 0) v[c] = ~v[c];
      r = ($urandom_range(0, 299) == 0);
      step(r, v);
    end

    step(1'b0, sw_in);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
